ov7670_frame_capture: RTL and testbench
=======================================

OV7670_FRAME_CAPTURE -- requirements
Module: ov7670_frame_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 320: pixels stored per line.
REQ-002 SHALL have parameter V_ACTIVE, default 240: lines stored per frame.
REQ-003 SHALL have parameter PIX_W, default 16: width of the write-data port.
REQ-004 SHALL have a derived localparam ADDR_W = $clog2(H_ACTIVE*V_ACTIVE).
REQ-005 SHALL have port clk, input, 1: the single clock, shared with the frame-buffer write port. One clock; reset is asynchronous and active-low.
REQ-006 SHALL have port reset_, input, 1: asynchronous active-low reset.
REQ-007 SHALL have ports pclk, href, vsync, input, 1 each: raw camera timing pins, asynchronous to clk.
REQ-008 SHALL have port d, input, 8: raw camera data bus.
REQ-009 SHALL have port mode, input, 2: pixel format. 0 = RGB565, 1 = RGB444 (xR,GB), 2 = RAW8, 3 = reserved, treated as RAW8.
REQ-010 SHALL have port capture_en, input, 1: arms capture; sampled only at frame start.
REQ-011 SHALL have ports wr_addr (output, ADDR_W), wr_data (output, PIX_W) and wr_dv (output, 1): the frame-buffer write port.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse at frame end.
REQ-013 SHALL have port frame_short, output, 1: sticky flag, set for the last frame that had fewer than V_ACTIVE lines.
REQ-014 SHALL have port line_ovf, output, 1: sticky flag, set when a line exceeded H_ACTIVE pixels or a frame exceeded V_ACTIVE lines.

Function
REQ-015 pclk, href, vsync and d SHALL each pass through a 2-flop synchronizer of identical depth, so byte and strobe stay aligned.
REQ-016 A pclk rise SHALL be detected as sync=1 with previous sync=0; each byte SHALL be sampled on that detection cycle only.
REQ-017 The FSM SHALL have three states: IDLE, WAIT_FRAME and ACTIVE.
REQ-018 IDLE -> WAIT_FRAME SHALL occur when capture_en=1 and vsync sync=1.
REQ-019 WAIT_FRAME -> ACTIVE SHALL occur on a vsync falling edge. On this transition the FSM SHALL clear the column, line and address counters and latch mode.
REQ-020 ACTIVE -> IDLE SHALL occur on a vsync rising edge. That transition SHALL pulse frame_done for exactly 1 cycle.
REQ-021 In RGB565 mode, byte0 SHALL be high and byte1 low; wr_data = {byte0,byte1}.
REQ-022 In RGB444 mode, wr_data SHALL be zero-extended {byte0[3:0],byte1}.
REQ-023 In RAW8 mode, every byte SHALL be one pixel; wr_data = zero-extended byte.
REQ-024 A byte phase toggle SHALL exist, cleared when href=0.
REQ-025 If href falls with odd phase, the partial pixel SHALL be dropped without any write.
REQ-026 wr_dv SHALL be high for exactly 1 cycle, on the cycle after the pclk-rise detection that completes a pixel. wr_addr and wr_data SHALL be valid while wr_dv=1.
REQ-027 Total latency from the raw pclk rise to wr_dv SHALL be 4 clk cycles (2 sync, 1 detect, 1 register).
REQ-028 wr_addr SHALL be computed incrementally (no multiplier): +1 per written pixel.
REQ-029 At each href fall after a non-empty line, wr_addr SHALL realign to line*H_ACTIVE.
REQ-030 A pixel with column >= H_ACTIVE SHALL be discarded and SHALL set line_ovf.
REQ-031 A line with index >= V_ACTIVE SHALL be discarded entirely and SHALL set line_ovf.
REQ-032 wr_addr SHALL never exceed H_ACTIVE*V_ACTIVE-1 and SHALL never wrap.
REQ-033 If vsync rises with line count < V_ACTIVE, frame_short SHALL be set. frame_short SHALL be cleared at the next frame_done of a full frame.
REQ-034 If vsync rises while href=1, the line SHALL be terminated with no further writes.
REQ-035 capture_en=0 during ACTIVE SHALL NOT abort the current frame; IDLE then holds.
REQ-036 The pclk-rise pipeline SHALL be ignored outside ACTIVE.

Reset
REQ-037 reset_=0 SHALL force the following immediately and asynchronously: FSM=IDLE, all counters=0, wr_dv=0, wr_addr=0, wr_data=0, frame_done=0, frame_short=0, line_ovf=0, synchronizers=0.
REQ-038 Reset mid-frame SHALL discard the frame; capture SHALL resume only after the next full vsync high-to-low sequence.

Configuration
REQ-039 Macro CAPTURE_STATS_EN, when defined, SHALL add outputs frame_cnt (16) and err_cnt (16). frame_cnt SHALL increment at each frame_done; err_cnt SHALL increment at each frame_done where frame_short or an overflow occurred in that frame. Both SHALL saturate at 16'hFFFF and reset to 0.
REQ-040 Without CAPTURE_STATS_EN, neither port nor its logic SHALL exist; all other behaviour SHALL be identical.

Structure
REQ-041 Package cam_pkg SHALL hold the typedef enum pix_mode_t (MODE_RGB565, MODE_RGB444, MODE_RAW8), the typedef enum cap_state_t, and constant SYNC_STAGES=2.
REQ-042 Sub-module sync_edge_det (2-flop synchronizer + rise/fall pulse outputs) SHALL be instantiated once per timing input; d SHALL use a plain 8-bit synchronizer.

Verification
REQ-043 Scenario: RGB565, H=4, V=2, bytes 0x12,0x34 per pixel -> 8 writes, wr_data=16'h1234, addr 0..7, frame_done once, no flags.
REQ-044 Scenario: RGB444, bytes 0xA5,0x6C -> wr_data=16'h056C.
REQ-045 Scenario: RAW8, H=4, line of 6 bytes -> 4 writes, line_ovf=1, next line starts at addr 4.
REQ-046 Scenario: href falls after 3 bytes in RGB565 -> 1 write only; next line's first pixel is correct.
REQ-047 Scenario: vsync rises after 1 of 2 lines -> frame_done pulse and frame_short=1; next full frame -> frame_short=0.
REQ-048 Scenario: reset_ low mid-line -> all outputs 0 immediately; no writes until vsync high then falls.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and helpers for the OV7670 capture block.
`timescale 1ns/1ps
package cam_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        MODE_RGB565 = 2'd0,
        MODE_RGB444 = 2'd1,
        MODE_RAW8   = 2'd2
    } pix_mode_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        ACTIVE     = 2'd2
    } cap_state_t;

    // The reserved encoding behaves as RAW8.
    function automatic pix_mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd0:    return MODE_RGB565;
            2'd1:    return MODE_RGB444;
            default: return MODE_RAW8;
        endcase
    endfunction

    function automatic logic [15:0] pack_pixel(input pix_mode_t m,
                                               input logic [7:0] b0,
                                               input logic [7:0] b1);
        case (m)
            MODE_RGB565: return {b0, b1};
            MODE_RGB444: return {4'h0, b0[3:0], b1};
            default:     return {8'h00, b1};
        endcase
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for one asynchronous level, with registered
// single-cycle rise and fall pulses.
`timescale 1ns/1ps
module sync_edge_det
    import cam_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/ov7670_frame_capture.sv
// OV7670 parallel-camera capture into a frame-buffer write port.
// Define CAPTURE_STATS_EN to add the frame_cnt / err_cnt statistics outputs.
`timescale 1ns/1ps
module ov7670_frame_capture
    import cam_pkg::*;
#(
    parameter  int H_ACTIVE = 320,
    parameter  int V_ACTIVE = 240,
    parameter  int PIX_W    = 16,
    localparam int ADDR_W   = $clog2(H_ACTIVE*V_ACTIVE)
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              pclk,
    input  logic              href,
    input  logic              vsync,
    input  logic [7:0]        d,
    input  logic [1:0]        mode,
    input  logic              capture_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              wr_dv,
    output logic              frame_done,
    output logic              frame_short,
    output logic              line_ovf
`ifdef CAPTURE_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       err_cnt
`endif
);

    localparam int COL_W  = $clog2(H_ACTIVE+1);
    localparam int LINE_W = $clog2(V_ACTIVE+1);
    localparam logic [COL_W-1:0]  H_LIM     = COL_W'(H_ACTIVE);
    localparam logic [LINE_W-1:0] V_LIM     = LINE_W'(V_ACTIVE);
    localparam logic [LINE_W-1:0] V_LAST    = LINE_W'(V_ACTIVE-1);
    localparam logic [ADDR_W-1:0] H_STEP    = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE*V_ACTIVE-1);

    logic w_pclk_rise, w_unused_pclk_lvl, w_unused_pclk_fall;
    logic w_href_sync, w_href_fall, w_unused_href_rise;
    logic w_vsync_sync, w_vsync_rise, w_vsync_fall;

    sync_edge_det u_sync_pclk (
        .i_clk   (clk),
        .i_rst_n (reset_),
        .i_async (pclk),
        .o_sync  (w_unused_pclk_lvl),
        .o_rise  (w_pclk_rise),
        .o_fall  (w_unused_pclk_fall)
    );

    sync_edge_det u_sync_href (
        .i_clk   (clk),
        .i_rst_n (reset_),
        .i_async (href),
        .o_sync  (w_href_sync),
        .o_rise  (w_unused_href_rise),
        .o_fall  (w_href_fall)
    );

    sync_edge_det u_sync_vsync (
        .i_clk   (clk),
        .i_rst_n (reset_),
        .i_async (vsync),
        .o_sync  (w_vsync_sync),
        .o_rise  (w_vsync_rise),
        .o_fall  (w_vsync_fall)
    );

    // Data bus gets the same depth as the strobes so a byte lines up with its pclk.
    logic [7:0] r_d_sync [SYNC_STAGES];
    logic [7:0] w_d;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_d_sync[i] <= '0;
        end else begin
            r_d_sync[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) r_d_sync[i] <= r_d_sync[i-1];
        end
    end

    assign w_d = r_d_sync[SYNC_STAGES-1];

    cap_state_t r_state, w_next;
    logic       w_start, w_end, w_active;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (capture_en && w_vsync_sync) w_next = WAIT_FRAME;
            WAIT_FRAME: if (w_vsync_fall)               w_next = ACTIVE;
            ACTIVE:     if (w_vsync_rise)               w_next = IDLE;
            default:                                    w_next = IDLE;
        endcase
    end

    always_comb begin
        w_start  = 1'b0;
        w_end    = 1'b0;
        w_active = 1'b0;
        case (r_state)
            WAIT_FRAME: w_start = w_vsync_fall;
            ACTIVE: begin
                w_active = 1'b1;
                w_end    = w_vsync_rise;
            end
            default: ;
        endcase
    end

    logic [COL_W-1:0]  r_col;
    logic [LINE_W-1:0] r_line;
    logic [ADDR_W-1:0] r_next_addr;
    logic [ADDR_W-1:0] r_base;
    logic              r_phase;
    logic              r_nonempty;
    logic [7:0]        r_byte0;
    pix_mode_t         r_mode;
    logic              r_frame_ovf;

    logic w_byte_ok, w_is_raw, w_px_done, w_line_in, w_col_in;
    logic w_write, w_ovf, w_full;

    // A vsync rise closes the frame, so a byte arriving with it is not written.
    assign w_byte_ok = w_active && w_pclk_rise && w_href_sync && !w_vsync_rise;
    assign w_is_raw  = (r_mode == MODE_RAW8);
    assign w_px_done = w_byte_ok && (w_is_raw || r_phase);
    assign w_line_in = (r_line < V_LIM);
    assign w_col_in  = (r_col < H_LIM);
    assign w_write   = w_px_done && w_line_in && w_col_in;
    assign w_ovf     = (w_byte_ok && !w_line_in) || (w_px_done && w_line_in && !w_col_in);
    assign w_full    = (r_line == V_LIM) || ((r_line == V_LAST) && r_nonempty);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_col       <= '0;
            r_line      <= '0;
            r_next_addr <= '0;
            r_base      <= '0;
            r_phase     <= 1'b0;
            r_nonempty  <= 1'b0;
            r_byte0     <= '0;
            r_mode      <= MODE_RGB565;
            r_frame_ovf <= 1'b0;
        end else if (w_start) begin
            r_col       <= '0;
            r_line      <= '0;
            r_next_addr <= '0;
            r_base      <= '0;
            r_phase     <= 1'b0;
            r_nonempty  <= 1'b0;
            r_mode      <= decode_mode(mode);
            r_frame_ovf <= 1'b0;
        end else if (w_active) begin
            if (!w_href_sync)
                r_phase <= 1'b0;
            else if (w_byte_ok && !w_is_raw)
                r_phase <= ~r_phase;

            if (w_byte_ok) begin
                r_nonempty <= 1'b1;
                if (!w_is_raw && !r_phase) r_byte0 <= w_d;
            end

            if (w_px_done && (r_col != H_LIM)) r_col <= r_col + 1'b1;
            if (w_write && (r_next_addr != ADDR_LAST)) r_next_addr <= r_next_addr + 1'b1;

            // Line end: step the base by one line instead of multiplying, and
            // stop moving it on the last stored line so the address never wraps.
            if (w_href_fall && r_nonempty) begin
                r_col      <= '0;
                r_nonempty <= 1'b0;
                if (r_line != V_LIM) r_line <= r_line + 1'b1;
                if (r_line < V_LAST) begin
                    r_base      <= r_base + H_STEP;
                    r_next_addr <= r_base + H_STEP;
                end
            end

            if (w_ovf) r_frame_ovf <= 1'b1;
        end
    end

    logic [ADDR_W-1:0] r_wr_addr;
    logic [PIX_W-1:0]  r_wr_data;
    logic              r_wr_dv;
    logic              r_frame_done;
    logic              r_frame_short;
    logic              r_line_ovf;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_wr_dv       <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_short <= 1'b0;
            r_line_ovf    <= 1'b0;
        end else begin
            r_wr_dv      <= w_write;
            r_frame_done <= w_end;
            if (w_write) begin
                r_wr_addr <= r_next_addr;
                r_wr_data <= PIX_W'(pack_pixel(r_mode, r_byte0, w_d));
            end
            if (w_ovf) r_line_ovf    <= 1'b1;
            if (w_end) r_frame_short <= ~w_full;
        end
    end

    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign wr_dv       = r_wr_dv;
    assign frame_done  = r_frame_done;
    assign frame_short = r_frame_short;
    assign line_ovf    = r_line_ovf;

`ifdef CAPTURE_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else if (w_end) begin
            if (r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
            if ((!w_full || r_frame_ovf) && (r_err_cnt != 16'hFFFF))
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Directed bench for ov7670_frame_capture with a 4x2 frame geometry.
`timescale 1ns/1ps
module tb_ov7670_frame_capture;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = $clog2(H*V);

    logic          clk;
    logic          reset_;
    logic          pclk, href, vsync, capture_en;
    logic [7:0]    d;
    logic [1:0]    mode;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          wr_dv, frame_done, frame_short, line_ovf;

    ov7670_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(16)) dut (
        .clk         (clk),
        .reset_      (reset_),
        .pclk        (pclk),
        .href        (href),
        .vsync       (vsync),
        .d           (d),
        .mode        (mode),
        .capture_en  (capture_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_dv       (wr_dv),
        .frame_done  (frame_done),
        .frame_short (frame_short),
        .line_ovf    (line_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  m;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp_d;
        int          exp_n;
    } vec_t;

    vec_t          tbl [6];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            fd_cnt  = 0;
    logic [AW-1:0] wa_q [$];
    logic [15:0]   wd_q [$];

    always @(negedge clk) begin
        if (wr_dv) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (frame_done) fd_cnt++;
    end

    function automatic logic [31:0] qa(input int i);
        if (i < wa_q.size()) return 32'(wa_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] qd(input int i);
        if (i < wd_q.size()) return 32'(wd_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        d = b;
        wclk(2);
        pclk = 1'b1;
        wclk(3);
        pclk = 1'b0;
        wclk(2);
    endtask

    task automatic send_pix(input logic [7:0] b0, input logic [7:0] b1);
        send_byte(b0);
        send_byte(b1);
    endtask

    task automatic start_frame(input logic [1:0] m);
        wa_q.delete();
        wd_q.delete();
        fd_cnt     = 0;
        mode       = m;
        capture_en = 1'b1;
        vsync      = 1'b1;
        wclk(6);
        vsync = 1'b0;
        wclk(6);
    endtask

    task automatic end_frame();
        href = 1'b0;
        wclk(6);
        vsync = 1'b1;
        wclk(8);
    endtask

    task automatic line_on();
        href = 1'b1;
        wclk(3);
    endtask

    task automatic line_off();
        href = 1'b0;
        wclk(6);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset_ = 1'b0; pclk = 1'b0; href = 1'b0; vsync = 1'b0;
        d = 8'h00; mode = 2'd0; capture_en = 1'b0;

        tbl[0] = '{2'd0, 8'h12, 8'h34, 16'h1234, 1};
        tbl[1] = '{2'd1, 8'hA5, 8'h6C, 16'h056C, 1};
        tbl[2] = '{2'd2, 8'h5A, 8'hC3, 16'h005A, 2};
        tbl[3] = '{2'd3, 8'h7E, 8'h01, 16'h007E, 2};
        tbl[4] = '{2'd0, 8'hFF, 8'h00, 16'hFF00, 1};
        tbl[5] = '{2'd1, 8'hFF, 8'hFF, 16'h0FFF, 1};

        wclk(3); #1;
        chk("rst_wr_dv", wr_dv, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_short", frame_short, 0);
        chk("rst_line_ovf", line_ovf, 0);
        reset_ = 1'b1;
        wclk(3);

        // Full RGB565 frame
        start_frame(2'd0);
        for (int l = 0; l < V; l++) begin
            line_on();
            repeat (H) send_pix(8'h12, 8'h34);
            line_off();
        end
        end_frame();
        chk("full_nwr", wa_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("full_addr%0d", i), qa(i), i);
            chk($sformatf("full_data%0d", i), qd(i), 32'h1234);
        end
        chk("full_fd", fd_cnt, 1);
        chk("full_short", frame_short, 0);
        chk("full_ovf", line_ovf, 0);

        // Short frame then full frame clears frame_short
        start_frame(2'd0);
        line_on();
        repeat (H) send_pix(8'h56, 8'h78);
        line_off();
        end_frame();
        chk("short_nwr", wa_q.size(), 4);
        chk("short_fd", fd_cnt, 1);
        chk("short_flag", frame_short, 1);
        start_frame(2'd0);
        for (int l = 0; l < V; l++) begin
            line_on();
            repeat (H) send_pix(8'h9A, 8'hBC);
            line_off();
        end
        end_frame();
        chk("reful_nwr", wa_q.size(), 8);
        chk("reful_last_addr", qa(7), 7);
        chk("reful_fd", fd_cnt, 1);
        chk("reful_short", frame_short, 0);

        // Pixel format table, one single-pixel line per frame
        for (int i = 0; i < 6; i++) begin
            start_frame(tbl[i].m);
            line_on();
            send_pix(tbl[i].b0, tbl[i].b1);
            line_off();
            end_frame();
            chk($sformatf("tbl%0d_nwr", i), wa_q.size(), tbl[i].exp_n);
            chk($sformatf("tbl%0d_addr", i), qa(0), 0);
            chk($sformatf("tbl%0d_data", i), qd(0), 32'(tbl[i].exp_d));
            chk($sformatf("tbl%0d_fd", i), fd_cnt, 1);
            chk($sformatf("tbl%0d_short", i), frame_short, 1);
        end

        // Odd-length line drops the trailing half pixel
        start_frame(2'd0);
        line_on();
        send_pix(8'h12, 8'h34);
        send_byte(8'h56);
        line_off();
        line_on();
        send_pix(8'hAB, 8'hCD);
        send_pix(8'hEF, 8'h01);
        line_off();
        end_frame();
        chk("odd_nwr", wa_q.size(), 3);
        chk("odd_a0", qa(0), 0);
        chk("odd_d0", qd(0), 32'h1234);
        chk("odd_a1", qa(1), 4);
        chk("odd_d1", qd(1), 32'hABCD);
        chk("odd_a2", qa(2), 5);
        chk("odd_d2", qd(2), 32'hEF01);
        chk("odd_ovf", line_ovf, 0);

        // Latency from raw pclk rise to wr_dv, RAW8
        start_frame(2'd2);
        line_on();
        d = 8'h77;
        wclk(3);
        @(posedge clk); #1;
        pclk = 1'b1;
        lat = 99;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (wr_dv) begin
                lat = n;
                break;
            end
        end
        chk("lat_cycles", lat, 4);
        chk("lat_data", wr_data, 32'h0077);
        @(posedge clk); #1;
        chk("lat_dv_width", wr_dv, 0);
        pclk = 1'b0;
        wclk(3);
        line_off();
        end_frame();

        // Column and line overflow in RAW8
        start_frame(2'd2);
        line_on();
        for (int b = 0; b < 6; b++) send_byte(8'h10 + 8'(b));
        line_off();
        chk("ovf_col_flag", line_ovf, 1);
        line_on();
        send_byte(8'h20);
        line_off();
        line_on();
        send_byte(8'h30);
        send_byte(8'h31);
        line_off();
        end_frame();
        chk("ovf_nwr", wa_q.size(), 5);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_a%0d", i), qa(i), i);
            chk($sformatf("ovf_d%0d", i), qd(i), 32'h10 + i);
        end
        chk("ovf_a4", qa(4), 4);
        chk("ovf_d4", qd(4), 32'h0020);
        chk("ovf_fd", fd_cnt, 1);
        chk("ovf_short", frame_short, 0);

        // Asynchronous reset in the middle of a line
        start_frame(2'd0);
        line_on();
        send_pix(8'h12, 8'h34);
        send_pix(8'h56, 8'h78);
        send_byte(8'h9A);
        chk("pre_rst_addr", wr_addr, 1);
        @(posedge clk); #3;
        reset_ = 1'b0;
        #1;
        chk("mid_rst_addr", wr_addr, 0);
        chk("mid_rst_data", wr_data, 0);
        chk("mid_rst_dv", wr_dv, 0);
        chk("mid_rst_ovf", line_ovf, 0);
        chk("mid_rst_short", frame_short, 0);
        chk("mid_rst_fd", frame_done, 0);
        wclk(3);
        reset_ = 1'b1;
        wclk(2);
        wa_q.delete();
        wd_q.delete();
        send_pix(8'h12, 8'h34);
        send_pix(8'h56, 8'h78);
        line_off();
        line_on();
        send_pix(8'h11, 8'h22);
        line_off();
        chk("post_rst_nwr", wa_q.size(), 0);
        chk("post_rst_fd", fd_cnt, 0);
        start_frame(2'd0);
        line_on();
        send_pix(8'hCA, 8'hFE);
        line_off();
        end_frame();
        chk("resume_nwr", wa_q.size(), 1);
        chk("resume_addr", qa(0), 0);
        chk("resume_data", qd(0), 32'hCAFE);
        chk("resume_fd", fd_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
